fib_sig_checker: RTL and testbench
==================================

# fib_sig_checker

Self-checking stimulus/response partner for the 8-bit Fibonacci signal generator top level, which has a 1-bit command input `__in0` and an 8-bit output `__out0`. The block drives the generator's command bit from a selectable pattern and predicts every returned byte with a cycle-accurate reference model. It accumulates mismatches and records the first failure, and it sits beside the generator in the regression harness, sharing its clock and reset.

## Interface
- `STEP_W`, 16: width of step count and error counters.
- `clk`  in  1  clock; shared with the generator.
- `rst`  in  1  reset; one clock, synchronous, active-high; shared with the generator.
- `start`  in  1  pulse; begins a run in IDLE or DONE, ignored in RUN.
- `num_steps`  in  STEP_W  run length in cycles, sampled on `start`.
- `cmd_mode`  in  2  command pattern: 00 hold, 01 advance, 10 alternate, 11 LFSR; sampled on `start`.
- `lfsr_seed`  in  8  LFSR seed, sampled on `start`; 0 is replaced by 8'h01.
- `dut_in0`  out  1  command to the generator's `__in0`.
- `dut_out0`  in  8  byte from the generator's `__out0`, same cycle.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done` && `err_count`==0.
- `err_count`  out  STEP_W  mismatches, saturating at all-ones.
- `first_err_idx`  out  STEP_W  step index of the first mismatch.
- `first_err_exp`  out  8  expected byte at the first mismatch.
- `first_err_got`  out  8  received byte at the first mismatch.

## Operation
- Generator behaviour: it holds state (s0,s1), reset to (8'h00,8'h01). Its output is Mealy.
  - cmd 0: out = s0; state unchanged.
  - cmd 1: out = s1; next state = (s1, s0+s1 mod 256).
- Reference model: registers m0,m1 with the same reset and update rules. The model updates only in RUN.
- IDLE and DONE: `dut_in0`=0, so the generator holds and the model stays aligned across runs. m0,m1 are not reset by `start`.
- FSM IDLE -> RUN on `start`, with `num_steps`≠0.
  - On that `start`: latch `num_steps` and `cmd_mode`, load the LFSR, and clear `step`, `err_count` and the first-error fields.
  - `start` with `num_steps`=0 goes to DONE directly, with counters cleared and `pass`=1.
- RUN, each cycle:
  - cmd = f(mode): 00 -> 0; 01 -> 1; 10 -> ~step[0]; 11 -> lfsr[0].
  - `dut_in0` = cmd, driven combinationally from registered state.
  - exp = cmd ? m1 : m0.
  - If `dut_out0`≠exp: increment `err_count` (saturating). If this is the first mismatch, capture `step`, exp and `dut_out0`.
  - Update the model, increment `step`, and shift the LFSR (x^8+x^6+x^5+x^4+1, Fibonacci form, shift toward bit 0).
  - At `step`==`num_steps`-1, go to DONE.
- DONE holds `done` and all results until `start`. `start` in DONE behaves as in IDLE.
- First-error fields are zero when `err_count`=0.

## Timing
- Reset values:
  - Outputs: `busy`=0, `done`=0, `pass`=0, `dut_in0`=0, `err_count`=0, and first-error fields 0.
  - Internal: FSM IDLE, m0/m1 = 00/01.
- `rst` asserted mid-run returns the block to reset values on the next edge. The generator resets on the same edge, so the model stays aligned.
- `start` at edge t: `busy`=1 from t+1, and the first comparison happens in cycle t+1.
- A run of N steps: `done`=1 from edge t+N+1, and `busy` falls on the same edge.
- Comparison and capture use the `dut_out0` value present in the cycle `dut_in0` is driven. There is no pipeline delay.
- `start` while `busy` is ignored.

## Structure
- Package `fib_chk_pkg` holds:
  - the FSM enum {IDLE, RUN, DONE};
  - `cmd_mode` constants;
  - LFSR tap mask 8'hB8;
  - reset constants S0_RST=8'h00 and S1_RST=8'h01.
- Sub-module `fib_ref_model` contains m0/m1, the `en`/`cmd` inputs, the `exp` output and the mod-256 add.
- Top level contains the FSM, the command generator, the counters and the capture logic.

## Test plan
- Advance mode from reset, `num_steps`=12 -> bytes 1,1,2,3,5,8,13,21,34,55,89,144 match, `pass`=1, `err_count`=0.
- Advance mode, 14 steps -> step 12 expects 233 and step 13 expects 121 (mod-256 wrap), `pass`=1.
- Alternate mode, 6 steps from reset -> exp 1,1,1,1,2,2; then hold mode, 3 steps -> exp 2,2,2 (model preserved across runs).
- Advance mode with bench flipping bit 0 of `dut_out0` at step 3 -> `err_count`=1, `first_err_idx`=3, `first_err_exp`=3, `first_err_got`=2, `pass`=0.
- `num_steps`=0 -> `done`=1 one cycle after `start`, `pass`=1, `dut_in0` stays 0.
- Assert `rst` at step 5 of an LFSR run, then rerun with seed 0 -> `done`=0 and `busy`=0 after the reset edge; rerun uses seed 8'h01 and passes.

Source files
------------

// File: rtl/fib_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fib_chk_pkg
// Brief    : Shared types and constants for the Fibonacci generator checker.
// Revision : 1.0 - initial release
// ============================================================================
package fib_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam logic [1:0] c_mode_hold = 2'b00;
    localparam logic [1:0] c_mode_adv  = 2'b01;
    localparam logic [1:0] c_mode_alt  = 2'b10;
    localparam logic [1:0] c_mode_lfsr = 2'b11;

    // Taps for x^8+x^6+x^5+x^4+1 with the register shifting toward bit 0
    localparam logic [7:0] c_lfsr_taps = 8'hB8;
    localparam logic [7:0] c_lfsr_dflt = 8'h01;

    localparam logic [7:0] S0_RST = 8'h00;
    localparam logic [7:0] S1_RST = 8'h01;

endpackage : fib_chk_pkg
`default_nettype wire

// File: rtl/fib_ref_model.sv
`default_nettype none
// ============================================================================
// Module   : fib_ref_model
// Brief    : Cycle-accurate Mealy model of the Fibonacci generator state.
// Revision : 1.0 - initial release
// ============================================================================
module fib_ref_model
    import fib_chk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cmd,
    output logic [7:0] exp
);

    logic [7:0] r_m0;
    logic [7:0] r_m1;
    logic [7:0] w_sum;

    assign w_sum = r_m0 + r_m1;
    assign exp   = cmd ? r_m1 : r_m0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m0 <= S0_RST;
            r_m1 <= S1_RST;
        end else if (en && cmd) begin
            r_m0 <= r_m1;
            r_m1 <= w_sum;
        end
    end

endmodule : fib_ref_model
`default_nettype wire

// File: rtl/fib_sig_checker.sv
`default_nettype none
// ============================================================================
// Module   : fib_sig_checker
// Brief    : Drives the Fibonacci generator command bit and checks its output.
// Revision : 1.0 - initial release
// ============================================================================
module fib_sig_checker
    import fib_chk_pkg::*;
#(
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [1:0]        cmd_mode,
    input  logic [7:0]        lfsr_seed,
    output logic              dut_in0,
    input  logic [7:0]        dut_out0,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [STEP_W-1:0] err_count,
    output logic [STEP_W-1:0] first_err_idx,
    output logic [7:0]        first_err_exp,
    output logic [7:0]        first_err_got
);

    fsm_state_t        r_state;
    fsm_state_t        w_state_nxt;
    logic [STEP_W-1:0] r_num_steps;
    logic [1:0]        r_mode;
    logic [7:0]        r_lfsr;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] r_err_count;
    logic [STEP_W-1:0] r_first_idx;
    logic [7:0]        r_first_exp;
    logic [7:0]        r_first_got;

    logic              w_run;
    logic              w_cmd;
    logic [7:0]        w_exp;
    logic              w_mismatch;
    logic              w_launch;
    logic              w_last_step;
    logic              w_lfsr_fb;

    assign w_run       = (r_state == RUN);
    assign w_launch    = start && !w_run;
    assign w_last_step = (r_step == r_num_steps - 1'b1);
    assign w_lfsr_fb   = ^(r_lfsr & c_lfsr_taps);

    always_comb begin
        w_cmd = 1'b0;
        case (r_mode)
            c_mode_hold: w_cmd = 1'b0;
            c_mode_adv:  w_cmd = 1'b1;
            c_mode_alt:  w_cmd = ~r_step[0];
            c_mode_lfsr: w_cmd = r_lfsr[0];
            default:     w_cmd = 1'b0;
        endcase
    end

    fib_ref_model u_ref_model (
        .clk (clk),
        .rst (rst),
        .en  (w_run),
        .cmd (w_cmd),
        .exp (w_exp)
    );

    assign w_mismatch = w_run && (dut_out0 != w_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dut_in0     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done = (r_state == DONE);
                if (start) begin
                    w_state_nxt = (num_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                dut_in0 = w_cmd;
                if (w_last_step) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_steps <= '0;
            r_mode      <= c_mode_hold;
            r_lfsr      <= c_lfsr_dflt;
            r_step      <= '0;
            r_err_count <= '0;
            r_first_idx <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else if (w_launch) begin
            r_num_steps <= num_steps;
            r_mode      <= cmd_mode;
            r_lfsr      <= (lfsr_seed == 8'h00) ? c_lfsr_dflt : lfsr_seed;
            r_step      <= '0;
            r_err_count <= '0;
            r_first_idx <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else if (w_run) begin
            r_step <= r_step + 1'b1;
            r_lfsr <= {w_lfsr_fb, r_lfsr[7:1]};
            if (w_mismatch) begin
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                // Only the earliest failure is kept for diagnosis
                if (r_err_count == '0) begin
                    r_first_idx <= r_step;
                    r_first_exp <= w_exp;
                    r_first_got <= dut_out0;
                end
            end
        end
    end

    assign err_count     = r_err_count;
    assign first_err_idx = r_first_idx;
    assign first_err_exp = r_first_exp;
    assign first_err_got = r_first_got;
    assign pass          = done && (r_err_count == '0);

endmodule : fib_sig_checker
`default_nettype wire

// File: tb/tb_fib_sig_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_sig_checker
// Brief    : Scoreboard bench with a behavioural generator and reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_sig_checker;

    localparam int STEP_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [STEP_W-1:0] num_steps = '0;
    logic [1:0]        cmd_mode = 2'b00;
    logic [7:0]        lfsr_seed = 8'h00;
    logic              dut_in0;
    logic [7:0]        dut_out0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [STEP_W-1:0] err_count;
    logic [STEP_W-1:0] first_err_idx;
    logic [7:0]        first_err_exp;
    logic [7:0]        first_err_got;

    always #5 clk = ~clk;

    fib_sig_checker #(.STEP_W(STEP_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_steps     (num_steps),
        .cmd_mode      (cmd_mode),
        .lfsr_seed     (lfsr_seed),
        .dut_in0       (dut_in0),
        .dut_out0      (dut_out0),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .first_err_got (first_err_got)
    );

    typedef struct {
        int errs;
        int idx;
        int exp;
        int got;
        int pss;
    } result_t;

    int      n_cmp  = 0;
    int      n_mism = 0;
    int      cmd_q[$];
    result_t res_q[$];

    // Stand-in for the generator, with an optional single-bit fault on its output
    logic [7:0] g0, g1;
    int         tb_step;
    bit         fault_on = 1'b0;
    int         fault_step = 0;
    logic       start_q = 1'b0;
    logic       done_d = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            g0 <= 8'h00;
            g1 <= 8'h01;
        end else if (dut_in0) begin
            g0 <= g1;
            g1 <= g0 + g1;
        end
        if (rst || !busy) tb_step <= 0;
        else              tb_step <= tb_step + 1;
        start_q <= start && !busy && !rst;
    end

    assign dut_out0 = (dut_in0 ? g1 : g0) ^
                      {7'b0, (fault_on && busy && (tb_step == fault_step))};

    // Bench-side reference: Fibonacci pair as plain integers
    int bm0 = 0;
    int bm1 = 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_mism++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (cmd_q.size() == 0) begin
                    n_cmp++;
                    n_mism++;
                    $display("FAIL cmd_underflow: busy with no expected command at %0t", $time);
                end else begin
                    chk("dut_in0", int'(dut_in0), cmd_q.pop_front());
                end
            end else begin
                chk("dut_in0_idle", int'(dut_in0), 0);
            end
            if (done && (!done_d || start_q)) begin
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_mism++;
                    $display("FAIL res_underflow: done with no expected result at %0t", $time);
                end else begin
                    result_t r;
                    r = res_q.pop_front();
                    chk("err_count", int'(err_count), r.errs);
                    chk("first_err_idx", int'(first_err_idx), r.idx);
                    chk("first_err_exp", int'(first_err_exp), r.exp);
                    chk("first_err_got", int'(first_err_got), r.got);
                    chk("pass", int'(pass), r.pss);
                end
            end
        end
        done_d = done;
    end

    task automatic issue(input int mode, input int n, input int seed,
                         input bit f_en, input int f_step);
        result_t r;
        int      l;
        int      c;
        int      e;
        int      fb;
        int      t;
        @(posedge clk);
        #1;
        num_steps  = STEP_W'(n);
        cmd_mode   = 2'(mode);
        lfsr_seed  = 8'(seed);
        fault_on   = f_en;
        fault_step = f_step;
        start      = 1'b1;
        r = '{errs: 0, idx: 0, exp: 0, got: 0, pss: 1};
        l = (seed == 0) ? 1 : seed;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       c = 0;
                1:       c = 1;
                2:       c = (i % 2 == 0) ? 1 : 0;
                default: c = l & 1;
            endcase
            cmd_q.push_back(c);
            e = c ? bm1 : bm0;
            if (f_en && i == f_step) begin
                r = '{errs: 1, idx: i, exp: e, got: e ^ 1, pss: 0};
            end
            if (c == 1) begin
                t   = bm1;
                bm1 = (bm0 + bm1) % 256;
                bm0 = t;
            end
            fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
            l  = ((l >> 1) | (fb << 7)) & 8'hFF;
        end
        res_q.push_back(r);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (!done) begin
            n_cmp++;
            n_mism++;
            $display("FAIL done_timeout: done=%0d after %0d cycles, required 1", done, budget);
        end
        @(negedge clk);
        #1;
        fault_on = 1'b0;
    endtask

    task automatic run(input int mode, input int n, input int seed,
                       input bit f_en, input int f_step);
        issue(mode, n, seed, f_en, f_step);
        wait_done(n + 10);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_q.delete();
        res_q.delete();
        bm0 = 0;
        bm1 = 1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_dut_in0", int'(dut_in0), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_first_err_idx", int'(first_err_idx), 0);
        rst = 1'b0;

        run(1, 12, 0, 1'b0, 0);
        pulse_rst();
        run(1, 14, 0, 1'b0, 0);
        pulse_rst();
        run(1, 14, 0, 1'b1, 12);
        pulse_rst();
        run(1, 14, 0, 1'b1, 13);

        pulse_rst();
        run(2, 6, 0, 1'b0, 0);
        run(0, 3, 0, 1'b1, 2);
        pulse_rst();
        run(1, 12, 0, 1'b1, 3);

        // Zero-length run: done one cycle after start, no commands issued
        issue(1, 0, 0, 1'b0, 0);
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 0);
        wait_done(4);

        // Reset in the middle of an LFSR run, then a seed-0 rerun
        issue(3, 20, 8'h5A, 1'b0, 0);
        begin
            int i;
            i = 0;
            while (tb_step != 5 && i < 40) begin
                @(posedge clk);
                #1;
                i++;
            end
        end
        chk("reached_step5", tb_step, 5);
        pulse_rst();
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err_count", int'(err_count), 0);
        run(3, 20, 0, 1'b0, 0);

        for (int k = 0; k < 10; k++) begin
            int m;
            int n;
            int s;
            bit f;
            m = int'($urandom_range(0, 3));
            n = int'($urandom_range(1, 30));
            s = int'($urandom_range(0, 255));
            f = 1'($urandom_range(0, 1));
            run(m, n, s, f, int'($urandom_range(0, n - 1)));
        end

        chk("res_q_drained", res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule : tb_fib_sig_checker
`default_nettype wire
